// File: rtl/game_pkg.sv
// Shared definitions for the sudoku game timer.
// Provides the timer FSM state type, the seconds field width/limit and a
// helper that clamps a raw seconds value into the 0..59 range.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam int unsigned SECONDS_W = 6;
  localparam logic [SECONDS_W-1:0] SECONDS_MAX = 6'd59;

  function automatic logic [SECONDS_W-1:0] clamp_seconds(input logic [SECONDS_W-1:0] s);
    return (s > SECONDS_MAX) ? SECONDS_MAX : s;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// One-second divider for the game timer.
// Counts enabled cycles modulo CLK_FREQ; tick_o is high in the enabled cycle
// in which the counter wraps, so the consumer updates on that same edge.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset, counter to 0
//   clear  - synchronous clear, counter to 0 (restart of timing)
//   enable - advance the counter this cycle; when low the count is held
//   tick_o - wrap strobe (combinational from count and enable)
module tick_divider #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = enable && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Play-time timer for the sudoku game.
// Keeps a minutes:seconds value counting up (elapsed time, saturating at
// MAX_MINUTES:59) or down (time limit, expiring at 0:00), advanced once per
// CLK_FREQ running cycles. Supports start/restart, pause/resume and expiry.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   start                    - pulse: load value and enter RUN (any state)
//   pause                    - pulse: toggle RUN <-> PAUSE
//   countdown                - mode, sampled on start (1 = count down)
//   load_minutes/seconds     - countdown initial value, sampled on start
//   running/paused/expired   - state flags (RUN / PAUSE / DONE)
//   tick                     - one-cycle pulse with each value update
//   minutes/seconds/playtime - current value, playtime = {minutes, seconds}
module game_timer
  import game_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned MIN_W       = 5,
  parameter int unsigned MAX_MINUTES = 2**MIN_W - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       countdown,
  input  logic [MIN_W-1:0]           load_minutes,
  input  logic [SECONDS_W-1:0]       load_seconds,
  output logic                       running,
  output logic                       paused,
  output logic                       expired,
  output logic                       tick,
  output logic [MIN_W-1:0]           minutes,
  output logic [SECONDS_W-1:0]       seconds,
  output logic [MIN_W+SECONDS_W-1:0] playtime
);

  localparam logic [MIN_W-1:0] MAX_M = MIN_W'(MAX_MINUTES);

  timer_state_t         state_q, state_d;
  logic [MIN_W-1:0]     min_q, min_d;
  logic [SECONDS_W-1:0] sec_q, sec_d;
  logic                 cd_q, cd_d;
  logic                 tick_q, tick_d;
  logic                 div_tick;
  logic                 div_en;

  // Divider only advances in RUN cycles that are not consumed by a
  // start or pause pulse, so a pause can never let a wrap slip through.
  assign div_en = (state_q == RUN) && !start && !pause;

  tick_divider #(
    .CLK_FREQ(CLK_FREQ)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .enable(div_en),
    .tick_o(div_tick)
  );

  // Next-value arithmetic for both count directions.
  logic [MIN_W-1:0]     up_min, dn_min;
  logic [SECONDS_W-1:0] up_sec, dn_sec;

  always_comb begin
    if (sec_q >= SECONDS_MAX) begin
      up_sec = '0;
      up_min = min_q + MIN_W'(1);
    end else begin
      up_sec = sec_q + SECONDS_W'(1);
      up_min = min_q;
    end
    if (sec_q == '0) begin
      dn_sec = SECONDS_MAX;
      dn_min = min_q - MIN_W'(1);
    end else begin
      dn_sec = sec_q - SECONDS_W'(1);
      dn_min = min_q;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      cd_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      cd_q    <= cd_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state and datapath update. Priority: start, zero-load expiry,
  // pause, seconds update.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cd_d    = cd_q;
    tick_d  = 1'b0;
    if (start) begin
      state_d = RUN;
      cd_d    = countdown;
      if (countdown) begin
        min_d = load_minutes;
        sec_d = clamp_seconds(load_seconds);
      end else begin
        min_d = '0;
        sec_d = '0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (cd_q && (min_q == '0) && (sec_q == '0)) begin
            // Countdown loaded with 0:00 expires without a tick.
            state_d = DONE;
          end else if (pause) begin
            state_d = PAUSE;
          end else if (div_tick) begin
            tick_d = 1'b1;
            if (cd_q) begin
              min_d = dn_min;
              sec_d = dn_sec;
              if ((dn_min == '0) && (dn_sec == '0)) state_d = DONE;
            end else begin
              min_d = up_min;
              sec_d = up_sec;
              if ((up_min == MAX_M) && (up_sec == SECONDS_MAX)) state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (pause) state_d = RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    running  = (state_q == RUN);
    paused   = (state_q == PAUSE);
    expired  = (state_q == DONE);
    tick     = tick_q;
    minutes  = min_q;
    seconds  = sec_q;
    playtime = {min_q, sec_q};
  end

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer with CLK_FREQ=4, MIN_W=3,
// MAX_MINUTES=7. Inputs change 1 time unit after a rising edge; outputs are
// checked at the same point, i.e. they reflect the cycle after that edge.
module tb_game_timer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic       countdown;
  logic [2:0] load_minutes;
  logic [5:0] load_seconds;
  logic       running;
  logic       paused;
  logic       expired;
  logic       tick;
  logic [2:0] minutes;
  logic [5:0] seconds;
  logic [8:0] playtime;

  int unsigned vectors;
  int unsigned errors;
  int unsigned nticks;

  game_timer #(
    .CLK_FREQ   (4),
    .MIN_W      (3),
    .MAX_MINUTES(7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .countdown   (countdown),
    .load_minutes(load_minutes),
    .load_seconds(load_seconds),
    .running     (running),
    .paused      (paused),
    .expired     (expired),
    .tick        (tick),
    .minutes     (minutes),
    .seconds     (seconds),
    .playtime    (playtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc();
  endtask

  task automatic run_ticks(input int unsigned n, output int unsigned cnt);
    cnt = 0;
    for (int unsigned i = 0; i < n; i++) begin
      cyc();
      if (tick === 1'b1) cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".running"}, 32'(running), 0);
    chk({tag, ".paused"}, 32'(paused), 0);
    chk({tag, ".expired"}, 32'(expired), 0);
    chk({tag, ".tick"}, 32'(tick), 0);
    chk({tag, ".minutes"}, 32'(minutes), 0);
    chk({tag, ".seconds"}, 32'(seconds), 0);
    chk({tag, ".playtime"}, 32'(playtime), 0);
  endtask

  task automatic do_start(input logic cd, input logic [2:0] m, input logic [5:0] s);
    countdown    = cd;
    load_minutes = m;
    load_seconds = s;
    start        = 1'b1;
    cyc();
    start        = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    errors       = 0;
    reset        = 1'b1;
    start        = 1'b0;
    pause        = 1'b0;
    countdown    = 1'b0;
    load_minutes = '0;
    load_seconds = '0;
    run(2);
    reset = 1'b0;
    chk_zero("reset");

    // Reset mid-run: 9 cycles after running rises the value is 0:02.
    do_start(1'b0, 3'd0, 6'd0);
    chk("mid.running", 32'(running), 1);
    run(9);
    chk("mid.seconds", 32'(seconds), 2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_zero("mid_reset");
    run(8);
    chk("mid.no_restart_run", 32'(running), 0);
    chk("mid.no_restart_sec", 32'(seconds), 0);

    // Count-up: updates 4 and 8 cycles after running rises.
    do_start(1'b0, 3'd5, 6'd30);
    chk("up.running", 32'(running), 1);
    chk("up.load", 32'(playtime), 0);
    run(3);
    chk("up.pre_tick", 32'(tick), 0);
    chk("up.pre_sec", 32'(seconds), 0);
    cyc();
    chk("up.tick1", 32'(tick), 1);
    chk("up.sec1", 32'(seconds), 1);
    cyc();
    chk("up.tick1_end", 32'(tick), 0);
    run(3);
    chk("up.tick2", 32'(tick), 1);
    chk("up.sec2", 32'(seconds), 2);
    chk("up.playtime", 32'(playtime), 2);

    // Count-up saturation: 479 updates from 0:00 reach 7:59.
    do_start(1'b0, 3'd0, 6'd0);
    run(239);
    chk("sat.0_59", 32'(playtime), 59);
    cyc();
    chk("sat.1_00", 32'(playtime), 64);
    chk("sat.1_00_tick", 32'(tick), 1);
    run(1675);
    chk("sat.7_58", 32'(playtime), 7 * 64 + 58);
    chk("sat.7_58_run", 32'(running), 1);
    chk("sat.7_58_exp", 32'(expired), 0);
    cyc();
    chk("sat.min", 32'(minutes), 7);
    chk("sat.sec", 32'(seconds), 59);
    chk("sat.tick", 32'(tick), 1);
    chk("sat.expired", 32'(expired), 1);
    chk("sat.running", 32'(running), 0);
    run_ticks(20, nticks);
    chk("sat.hold_ticks", nticks, 0);
    chk("sat.hold_val", 32'(playtime), 7 * 64 + 59);
    chk("sat.hold_exp", 32'(expired), 1);

    // Countdown from 1:00: first update 0:59, expiry after 60 updates.
    do_start(1'b1, 3'd1, 6'd0);
    chk("cd.load", 32'(playtime), 64);
    chk("cd.running", 32'(running), 1);
    run(4);
    chk("cd.first", 32'(playtime), 59);
    chk("cd.first_tick", 32'(tick), 1);
    run(235);
    chk("cd.0_01", 32'(playtime), 1);
    chk("cd.0_01_exp", 32'(expired), 0);
    cyc();
    chk("cd.0_00", 32'(playtime), 0);
    chk("cd.end_tick", 32'(tick), 1);
    chk("cd.expired", 32'(expired), 1);
    chk("cd.running", 32'(running), 0);

    // Clamp of load seconds.
    do_start(1'b1, 3'd0, 6'd62);
    chk("clamp.0_62", 32'(playtime), 59);
    do_start(1'b1, 3'd3, 6'd63);
    chk("clamp.3_63", 32'(playtime), 3 * 64 + 59);

    // Pause after two divider cycles, hold 10, resume: update after 2 more.
    do_start(1'b0, 3'd0, 6'd0);
    run(2);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("pause.paused", 32'(paused), 1);
    chk("pause.running", 32'(running), 0);
    run_ticks(10, nticks);
    chk("pause.no_ticks", nticks, 0);
    chk("pause.hold_sec", 32'(seconds), 0);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("resume.running", 32'(running), 1);
    chk("resume.paused", 32'(paused), 0);
    cyc();
    chk("resume.no_tick", 32'(tick), 0);
    cyc();
    chk("resume.tick", 32'(tick), 1);
    chk("resume.sec", 32'(seconds), 1);

    // Start and pause together: start wins, from RUN and from PAUSE.
    countdown = 1'b0;
    start = 1'b1;
    pause = 1'b1;
    cyc();
    start = 1'b0;
    pause = 1'b0;
    chk("sp_run.running", 32'(running), 1);
    chk("sp_run.paused", 32'(paused), 0);
    chk("sp_run.sec", 32'(seconds), 0);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("sp_pause.pre", 32'(paused), 1);
    start = 1'b1;
    pause = 1'b1;
    cyc();
    start = 1'b0;
    pause = 1'b0;
    chk("sp_pause.running", 32'(running), 1);
    chk("sp_pause.paused", 32'(paused), 0);

    // Zero countdown: expired two cycles after start, no tick; pause in DONE.
    do_start(1'b1, 3'd0, 6'd0);
    chk("zero.running", 32'(running), 1);
    chk("zero.exp_early", 32'(expired), 0);
    cyc();
    chk("zero.expired", 32'(expired), 1);
    chk("zero.running_off", 32'(running), 0);
    chk("zero.tick", 32'(tick), 0);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("done_pause.expired", 32'(expired), 1);
    chk("done_pause.paused", 32'(paused), 0);
    run_ticks(8, nticks);
    chk("done_pause.ticks", nticks, 0);
    chk("done_pause.val", 32'(playtime), 0);

    // Restart from DONE and a final reset while expired.
    do_start(1'b1, 3'd2, 6'd10);
    chk("restart.val", 32'(playtime), 2 * 64 + 10);
    chk("restart.running", 32'(running), 1);
    do_start(1'b1, 3'd0, 6'd0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_zero("done_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Parametrised play-time timer for the sudoku game. It derives a one-second tick from the system clock and keeps a minutes:seconds value that counts either up (elapsed play time) or down (time-limited mode). Pause/resume, expiry detection and a packed playtime bus are provided for the display and score logic in the top level.

## Interface

Parameters:

- `CLK_FREQ`, 50_000_000: clock cycles per second, ≥ 2.
- `MIN_W`, 5: minutes field width.
- `MAX_MINUTES`, 2**MIN_W-1: count-up saturation minute; must be ≤ 2**MIN_W-1.

Ports:

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `start`  in  1  single-cycle pulse; loads and begins timing.
- `pause`  in  1  single-cycle pulse; toggles RUN↔PAUSE.
- `countdown`  in  1  mode select, sampled only on `start` (1 = count down).
- `load_minutes`  in  MIN_W  countdown initial minutes, sampled on `start`.
- `load_seconds`  in  6  countdown initial seconds, sampled on `start`; values > 59 are clamped to 59.
- `running`  out  1  high in RUN.
- `paused`  out  1  high in PAUSE.
- `expired`  out  1  high in DONE.
- `tick`  out  1  one-cycle pulse on each seconds update.
- `minutes`  out  MIN_W  current minutes.
- `seconds`  out  6  current seconds, 0..59.
- `playtime`  out  MIN_W+6  {minutes, seconds}.

## Operation

- States: IDLE, RUN, PAUSE, DONE.
- Reset: state IDLE, divider 0. All outputs 0: `running`, `paused`, `expired`, `tick`, `minutes`, `seconds`, `playtime`.
- `start` in any state:
  - → RUN, divider cleared.
  - Count-down: loads the clamped load values.
  - Count-up: loads 0:00.
  - Mode latched.
- A new `start` in RUN, PAUSE or DONE restarts immediately.
- `pause`:
  - RUN→PAUSE and PAUSE→RUN.
  - Ignored in IDLE and DONE.
  - The divider holds its value in PAUSE, so partial seconds are preserved.
- Simultaneous `start` and `pause`: `start` wins; `pause` is ignored.
- Divider: in RUN it increments each cycle. At CLK_FREQ-1 it wraps to 0 and a seconds update occurs.
- Count-up update:
  - Seconds 59 → 0 with minutes+1.
  - On reaching MAX_MINUTES:59 the value holds and state → DONE.
- Count-down update:
  - Seconds 0 → 59 with minutes-1.
  - On reaching 0:00 → DONE.
- Count-down start with load 0:00: → RUN, then → DONE on the next cycle with no tick.
- DONE holds the time value; only `start` or `reset` leaves it.

## Timing

- `start` sampled at edge t: `running`=1 and the loaded time are visible from cycle t+1.
- Seconds updates occur CLK_FREQ cycles apart while in RUN (pause time excluded).
  - The first update is visible CLK_FREQ cycles after `running` rises.
  - `tick` is high in exactly the cycle the new value first appears.
- `expired` rises in the same cycle as the final update/tick. `running` falls in that cycle.
- `pause` at edge t: `paused`=1 from t+1. No tick can occur in cycle t+1 or later while paused.
- `reset` at edge t: every output is 0 from t+1, including mid-count and in DONE.

## Structure

- Shared package `game_pkg`:
  - `timer_state_t` enum (IDLE, RUN, PAUSE, DONE).
  - `SECONDS_W` = 6.
  - `SECONDS_MAX` = 59.
- Sub-module `tick_divider`, parameter `CLK_FREQ`. Ports: `clk`, `reset`, `clear`, `enable`, `tick_o`.
- `game_timer` holds the FSM and the minutes/seconds arithmetic.

## Test plan

All scenarios use CLK_FREQ=4, MIN_W=3, MAX_MINUTES=7.

- **Reset mid-run.** Reset, then count-up `start`, then 9 cycles, then `reset` → all outputs 0 the next cycle; `start` required to resume.
- **Count-up.** Count-up `start` → seconds 1 at 4 cycles after `running`, 2 at 8. `tick` is a single-cycle pulse each time. `playtime` = {minutes, seconds}.
- **Count-up saturation.** Count-up run to 7:59 → `expired`=1, `running`=0. Value holds at 7:59 for 20 further cycles.
- **Countdown and clamp.** Countdown `start` with load 1:00 → next tick gives 0:59; expiry at 0:00 after 60 ticks. Load 0:62 → value 0:59.
- **Pause and start/pause precedence.**
  - Pause after 2 divider cycles, hold 10 cycles, then resume → next tick 2 cycles after resume.
  - `start` and `pause` in the same cycle → RUN, `paused`=0.
- **Zero countdown and pause in DONE.**
  - Countdown `start` with load 0:00 → `expired`=1 two cycles after `start`, no tick.
  - `pause` in DONE → no change.
